// File: rtl/serial_adder_subtractor.sv
// Multi-cycle two's-complement adder/subtractor: DIGIT bits per clock, LSB digit first.
// B is inverted and carry-in forced to Op for subtract; C is reported as borrow on subtract.
module serial_adder_subtractor #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Op,
  output logic [WIDTH-1:0] S,
  output logic             C,
  output logic             V,
  output logic             Z,
  output logic             N,
  output logic             done
);

  localparam int unsigned NDig = WIDTH / DIGIT;
  localparam int unsigned CntW = (NDig > 1) ? $clog2(NDig) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NDig - 1);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             op_q, carry_q;
  logic [CntW-1:0]  cnt_q;

  logic [DIGIT:0]   chain;
  logic [DIGIT-1:0] sum_dig;
  logic [WIDTH-1:0] res_next;
  logic             dig_cout, dig_cmsb;

  // One DIGIT-bit ripple over the low digit of the operand shift registers.
  always_comb begin
    chain    = '0;
    sum_dig  = '0;
    chain[0] = carry_q;
    for (int i = 0; i < int'(DIGIT); i++) begin
      sum_dig[i]   = a_q[i] ^ b_q[i] ^ chain[i];
      chain[i + 1] = (a_q[i] & b_q[i]) | (chain[i] & (a_q[i] ^ b_q[i]));
    end
    dig_cout = chain[DIGIT];
    // On the final digit this is the carry into bit WIDTH-1.
    dig_cmsb = chain[DIGIT-1];
    res_next = res_q >> DIGIT;
    res_next[WIDTH-1 -: DIGIT] = sum_dig;
  end

  assign ready = (state_q == StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      op_q    <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      S       <= '0;
      C       <= 1'b0;
      V       <= 1'b0;
      Z       <= 1'b0;
      N       <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            a_q     <= A;
            b_q     <= B ^ {WIDTH{Op}};
            op_q    <= Op;
            carry_q <= Op;
            cnt_q   <= '0;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          res_q   <= res_next;
          carry_q <= dig_cout;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            S       <= res_next;
            C       <= dig_cout ^ op_q;
            V       <= dig_cout ^ dig_cmsb;
            Z       <= (res_next == '0);
            N       <= res_next[WIDTH-1];
            done    <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/serial_adder_subtractor.md
Name: serial_adder_subtractor

Overview:
Parametrised, multi-cycle two's-complement adder/subtractor that processes DIGIT bits per clock, LSB digit first, across a WIDTH-bit operand. It uses the same add/subtract convention as the team's combinational 4-bit unit: B is XORed with Op, carry-in equals Op, and C is inverted for subtract. It adds a start/ready/done handshake and Z/N flags. It sits in the ALU datapath where wide operands must be handled with a narrow carry chain.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT, and WIDTH >= 2.
DIGIT, 4, bits processed per clock cycle; 1 <= DIGIT <= WIDTH.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
start  input  1  request a new operation; sampled only while ready=1.
ready  output  1  block is idle and will accept start this cycle.
A  input  WIDTH  augend/minuend; captured on an accepted start.
B  input  WIDTH  addend/subtrahend; captured on an accepted start.
Op  input  1  0 = add, 1 = subtract; captured on an accepted start.
S  output  WIDTH  sum/difference; registered, held until the next completion.
C  output  1  carry (add) or borrow (subtract); registered.
V  output  1  signed overflow; registered.
Z  output  1  S == 0; registered.
N  output  1  S[WIDTH-1]; registered.
done  output  1  one-cycle pulse when S and the flags update.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - S=0, C=0, V=0, Z=0, N=0, done=0, ready=1.
  - State goes to IDLE; the digit counter and internal shift registers are cleared.
  - An in-flight operation is discarded and produces no done pulse.
- States: IDLE and BUSY. ready = (state == IDLE), decoded from the state register only.
- IDLE, with start=1 at edge k (accepted start):
  - Latch A, Op, and B' = B XOR {WIDTH{Op}}.
  - Set carry register = Op and digit counter = 0.
  - Go to BUSY.
- BUSY: at each edge, one digit is processed.
  - sum_digit = A_digit + B'_digit + carry register, using a DIGIT-bit ripple.
  - The result digit shifts into the internal result register.
  - The carry register takes the digit carry-out.
  - The counter increments.
- Completion:
  - With NDIG = WIDTH/DIGIT, the last digit is processed at edge k+NDIG.
  - At that same edge, S, C, V, Z and N load their final values, done=1 for exactly one cycle, and the state returns to IDLE.
  - Total latency from the accepted-start edge to the done cycle is NDIG edges.
  - With DIGIT=WIDTH, done is asserted the cycle after start.
- Flag rules:
  - c_out is the carry out of bit WIDTH-1; c_msb is the carry into bit WIDTH-1. When DIGIT=1 this comes from the previous cycle's carry register; otherwise it is internal to the last digit.
  - C = c_out XOR Op_latched.
  - V = c_out XOR c_msb.
  - Z = (final S == 0).
  - N = final S[WIDTH-1].
- start while BUSY is ignored and is not queued. A, B and Op may change freely while BUSY without effect.
- Back-to-back: ready=1 in the done cycle, so a start in that cycle is accepted. Throughput is one result per NDIG cycles.
- S and the flags change only at a completion edge or on reset. Intermediate digits are never visible on S.
- Width arithmetic: results wrap modulo 2^WIDTH; no saturation.

Test Plan:
- WIDTH=16, DIGIT=4: add 0x7FFF + 0x0001 -> S=0x8000, C=0, V=1, N=1, Z=0. done is seen exactly 4 edges after the start edge, and ready=0 for those 4 cycles.
- Subtract 0x0003 - 0x0005 -> S=0xFFFE, C=1 (borrow), V=0, N=1, Z=0. Subtract 0x1234 - 0x1234 -> S=0x0000, C=0, V=0, Z=1.
- Add 0xFFFF + 0x0001 -> S=0x0000, C=1, V=0, Z=1. Subtract 0x8000 - 0x0001 -> S=0x7FFF, V=1, C=0.
- Pulse start again 2 cycles into an operation, with different A/B/Op -> ignored; the first result is unchanged. A start in the done cycle is accepted, and its result appears 4 edges later.
- Assert rst 2 cycles into an operation -> all outputs are 0 and ready=1 immediately (asynchronously); no done pulse follows. A new op after reset completes correctly.
- Repeat a random add/sub sweep against a reference model for (WIDTH, DIGIT) = (16,1), (16,16), (8,2) and (32,8) -> S, C, V, Z and N all match; done latency = WIDTH/DIGIT.
